// File: rtl/oflow_cr_scheduler_if.sv
// Score board port used by the conflict-resolve scheduler:
// CR read port plus pointer-write port.
interface oflow_cr_scheduler_if #(
    parameter int ROW_LEN   = 3,
    parameter int ID_LEN    = 12,
    parameter int SCORE_LEN = 16
);
    logic [ROW_LEN-1:0]   row_sel_from_cr;
    logic [SCORE_LEN-1:0] score_to_cr;
    logic [ID_LEN-1:0]    id_to_cr;
    logic                 write_to_pointer;
    logic [ROW_LEN-1:0]   row_to_change;
    logic                 data_from_cr;

    modport master (
        output row_sel_from_cr,
        output write_to_pointer,
        output row_to_change,
        output data_from_cr,
        input  score_to_cr,
        input  id_to_cr
    );

    modport slave (
        input  row_sel_from_cr,
        input  write_to_pointer,
        input  row_to_change,
        input  data_from_cr,
        output score_to_cr,
        output id_to_cr
    );
endinterface

// File: rtl/oflow_cr_scheduler.sv
// Conflict-resolve scheduler: repeated pairwise ID collision passes,
// flipping the losing row to its second choice until a pass is clean.
module oflow_cr_scheduler #(
    parameter int MAX_ROWS  = 8,
    parameter int ROW_LEN   = 3,
    parameter int ID_LEN    = 12,
    parameter int SCORE_LEN = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_cr,
    input  logic [ROW_LEN:0]     num_rows,
    output logic                 busy_cr,
    output logic                 done_cr,
    output logic                 unresolved_valid,
    output logic [ROW_LEN-1:0]   unresolved_row,
    oflow_cr_scheduler_if.master sb
);
    typedef enum logic [2:0] {
        IDLE, LOAD_I, CMP, WRITE, PASS_END, DONE
    } state_t;

    localparam logic [ROW_LEN:0] ONE  = (ROW_LEN+1)'(1);
    localparam logic [ROW_LEN:0] MAXN = (ROW_LEN+1)'(MAX_ROWS);

    state_t               state;
    state_t               adv_state;
    logic [ROW_LEN:0]     n, i, j;
    logic [ROW_LEN:0]     i_nxt, j_nxt, n_m1;
    logic [ROW_LEN:0]     adv_i, adv_j;
    logic [ROW_LEN-1:0]   adv_sel;
    logic [ROW_LEN:0]     n_clamped;
    logic [ID_LEN-1:0]    id_i;
    logic [SCORE_LEN-1:0] score_i;
    logic [MAX_ROWS-1:0]  ptr_shadow;
    logic                 changed;
    logic [ROW_LEN-1:0]   loser, loser_c;
    logic                 conflict;

    assign n_clamped = (num_rows > MAXN) ? MAXN : num_rows;
    assign i_nxt     = i + ONE;
    assign j_nxt     = j + ONE;
    assign n_m1      = n - ONE;
    assign conflict  = (id_i != '0) && (sb.id_to_cr == id_i);
    // Higher score loses; a tie goes against row j.
    assign loser_c   = (sb.score_to_cr < score_i) ? i[ROW_LEN-1:0]
                                                  : j[ROW_LEN-1:0];

    // Where the scan goes after finishing with the current (i, j) pair.
    always_comb begin
        adv_state = CMP;
        adv_i     = i;
        adv_j     = j_nxt;
        adv_sel   = j_nxt[ROW_LEN-1:0];
        if (j_nxt == n) begin
            adv_j = j;
            if (i_nxt == n_m1) begin
                adv_state = PASS_END;
                adv_sel   = '0;
            end else begin
                adv_state = LOAD_I;
                adv_i     = i_nxt;
                adv_sel   = i_nxt[ROW_LEN-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            n                   <= '0;
            i                   <= '0;
            j                   <= '0;
            id_i                <= '0;
            score_i             <= '0;
            ptr_shadow          <= '0;
            changed             <= 1'b0;
            loser               <= '0;
            busy_cr             <= 1'b0;
            done_cr             <= 1'b0;
            unresolved_valid    <= 1'b0;
            unresolved_row      <= '0;
            sb.row_sel_from_cr  <= '0;
            sb.write_to_pointer <= 1'b0;
            sb.row_to_change    <= '0;
            sb.data_from_cr     <= 1'b0;
        end else begin
            done_cr             <= 1'b0;
            unresolved_valid    <= 1'b0;
            sb.row_sel_from_cr  <= '0;
            sb.write_to_pointer <= 1'b0;
            sb.row_to_change    <= '0;
            sb.data_from_cr     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_cr) begin
                        n          <= n_clamped;
                        i          <= '0;
                        changed    <= 1'b0;
                        ptr_shadow <= '0;
                        busy_cr    <= 1'b1;
                        if (n_clamped <= ONE) begin
                            state   <= DONE;
                            done_cr <= 1'b1;
                        end else begin
                            state <= LOAD_I;
                        end
                    end
                end
                LOAD_I: begin
                    id_i               <= sb.id_to_cr;
                    score_i            <= sb.score_to_cr;
                    j                  <= i_nxt;
                    sb.row_sel_from_cr <= i_nxt[ROW_LEN-1:0];
                    state              <= CMP;
                end
                CMP: begin
                    if (conflict && !ptr_shadow[loser_c]) begin
                        loser               <= loser_c;
                        state               <= WRITE;
                        sb.write_to_pointer <= 1'b1;
                        sb.row_to_change    <= loser_c;
                        sb.data_from_cr     <= 1'b1;
                    end else begin
                        if (conflict) begin
                            unresolved_valid <= 1'b1;
                            unresolved_row   <= loser_c;
                        end
                        state              <= adv_state;
                        i                  <= adv_i;
                        j                  <= adv_j;
                        sb.row_sel_from_cr <= adv_sel;
                    end
                end
                WRITE: begin
                    ptr_shadow[loser] <= 1'b1;
                    changed           <= 1'b1;
                    // Row i now carries a new ID, so it is reloaded.
                    if (loser == i[ROW_LEN-1:0]) begin
                        state              <= LOAD_I;
                        sb.row_sel_from_cr <= i[ROW_LEN-1:0];
                    end else begin
                        state              <= adv_state;
                        i                  <= adv_i;
                        j                  <= adv_j;
                        sb.row_sel_from_cr <= adv_sel;
                    end
                end
                PASS_END: begin
                    if (changed) begin
                        changed <= 1'b0;
                        i       <= '0;
                        state   <= LOAD_I;
                    end else begin
                        state   <= DONE;
                        done_cr <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy_cr <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
